// File: rtl/opamp_mux_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | opamp_mux_sequencer                                                      |
// | Round-robin sequencer sharing one buffer op-amp and ADC among NREQ mux   |
// | channels: settle, convert, return the result with a one-cycle ACK.       |
// | Optional: TUB_ADC_TIMEOUT_EN adds a TMO-cycle ADC timeout with ERR.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module opamp_mux_sequencer #(
  parameter  int SW     = 2,
  parameter  int SETTLE = 16,
  parameter  int DW     = 12,
  parameter  int TMO    = 200,
  localparam int NREQ   = 2**SW
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] ACK,
  output logic [DW-1:0]   DATA,
  output logic [SW-1:0]   MUX_SEL,
  output logic            MUX_EN,
  output logic            ADC_START,
  input  logic            ADC_DONE,
  input  logic [DW-1:0]   ADC_DATA,
  output logic            BUSY,
  output logic            ERR
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [7:0] c_SETTLE_LD = 8'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 255 || TMO < 1 || TMO > 65535) begin : g_bad_param
    $error("opamp_mux_sequencer: SETTLE or TMO outside legal range");
  end

  state_t          r_state;
  logic [NREQ-1:0] r_pend;
  logic [SW-1:0]   r_ptr;
  logic [7:0]      r_cnt;
  logic [NREQ-1:0] r_ack;
  logic [DW-1:0]   r_data;
  logic [SW-1:0]   r_mux_sel;
  logic            r_mux_en;
  logic            r_adc_start;
  logic            r_busy;

  logic            w_gnt_vld;
  logic [SW-1:0]   w_gnt_idx;
  logic            w_gnt;
  logic [NREQ-1:0] w_gnt_mask;
  logic [NREQ-1:0] w_ack_hot;
  logic            w_done_ok;

`ifdef TUB_ADC_TIMEOUT_EN
  localparam logic [15:0] c_TMO = 16'(TMO);
  logic [15:0] r_tmo_cnt;
  logic        r_err;
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif

  // Scan downward so the candidate closest above the pointer is the last to win.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (r_pend[r_ptr + SW'(k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = r_ptr + SW'(k);
      end
    end
  end

  assign w_gnt      = (r_state == ST_IDLE) && w_gnt_vld;
  assign w_gnt_mask = w_gnt ? (NREQ'(1) << w_gnt_idx) : '0;
  assign w_ack_hot  = NREQ'(1) << r_mux_sel;
  // A DONE coincident with our own START belongs to no conversion of ours.
  assign w_done_ok  = ADC_DONE && !r_adc_start;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_data      <= '0;
      r_mux_sel   <= '0;
      r_mux_en    <= 1'b0;
      r_adc_start <= 1'b0;
      r_busy      <= 1'b0;
`ifdef TUB_ADC_TIMEOUT_EN
      r_tmo_cnt   <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_pend      <= (r_pend & ~w_gnt_mask) | REQ;
      r_ack       <= '0;
      r_adc_start <= 1'b0;
`ifdef TUB_ADC_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_gnt) begin
            r_mux_sel <= w_gnt_idx;
            r_mux_en  <= 1'b1;
            r_cnt     <= c_SETTLE_LD;
            r_busy    <= 1'b1;
            r_ptr     <= w_gnt_idx + SW'(1);
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == 8'd0) begin
            r_adc_start <= 1'b1;
            r_state     <= ST_CONVERT;
`ifdef TUB_ADC_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_CONVERT: begin
          if (w_done_ok) begin
            r_data   <= ADC_DATA;
            r_ack    <= w_ack_hot;
            r_mux_en <= 1'b0;
            r_state  <= ST_DONE;
          end
`ifdef TUB_ADC_TIMEOUT_EN
          else if (r_tmo_cnt == c_TMO) begin
            r_data   <= '1;
            r_err    <= 1'b1;
            r_ack    <= w_ack_hot;
            r_mux_en <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ACK       = r_ack;
  assign DATA      = r_data;
  assign MUX_SEL   = r_mux_sel;
  assign MUX_EN    = r_mux_en;
  assign ADC_START = r_adc_start;
  assign BUSY      = r_busy;

endmodule
`default_nettype wire

// File: doc/opamp_mux_sequencer.md
Name: opamp_mux_sequencer

Overview:
- Time-shares one buffer op-amp, fronted by an analog multiplexer, between NREQ analog monitor channels on the trigger utility board.
- Latches per-channel conversion requests and arbitrates them round-robin.
- For the granted channel: drives the mux select, waits a fixed op-amp settling time, starts the ADC, captures the result and returns it with a one-cycle acknowledge.

Parameters:
- SW, 2: mux select width; NREQ = 2**SW channels (4).
- SETTLE, 16: settling cycles between mux switch and ADC start; legal range 1..255.
- DW, 12: ADC result width.
- TMO, 200: ADC timeout in cycles; used only with TUB_ADC_TIMEOUT_EN; legal range 1..65535.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-channel request pulse; one cycle high sets that channel's pending bit.
- ACK  out  NREQ  one-hot, one-cycle pulse to the served channel; DATA is valid in that cycle.
- DATA  out  DW  last conversion result; holds until the next ACK.
- MUX_SEL  out  SW  analog mux channel select.
- MUX_EN  out  1  analog mux enable.
- ADC_START  out  1  one-cycle convert-start pulse.
- ADC_DONE  in  1  one-cycle conversion-complete pulse.
- ADC_DATA  in  DW  converter result; valid with ADC_DONE.
- BUSY  out  1  high in any state other than IDLE.
- ERR  out  1  timeout flag; pulses with ACK; tied 0 without the macro.

Behaviour:
- Reset (asynchronous, RESET_N low):
  - State = IDLE; pending = 0; round-robin pointer = 0.
  - ACK = 0, DATA = 0, MUX_SEL = 0, MUX_EN = 0, ADC_START = 0, BUSY = 0, ERR = 0.
  - Reset mid-conversion abandons the conversion silently, with no ACK.
- Pending register:
  - pending[i] is set by REQ[i] and cleared in the cycle channel i is granted.
  - A REQ on an already-pending channel is merged (no queuing depth).
  - A REQ on the channel currently in service sets pending again and yields a fresh conversion later.
  - A REQ in the same cycle as that channel's grant keeps the bit set: set wins.
- Arbitration: in IDLE, if any pending bit is set, grant the first set bit searching upward from the pointer, wrapping modulo NREQ. After a grant, pointer = granted index + 1 (mod NREQ).
- State machine:
  - IDLE -> SETTLE: on grant. Register MUX_SEL = index, MUX_EN = 1, load counter with SETTLE-1.
  - SETTLE: decrement each cycle; at 0 go to CONVERT with ADC_START = 1 for exactly one cycle.
  - CONVERT: wait for ADC_DONE. On ADC_DONE, register DATA = ADC_DATA and go to DONE.
  - DONE: one cycle, ACK[index] = 1, MUX_EN = 0; then IDLE.
- Latency: grant decision in cycle t gives MUX_EN at t+1, ADC_START at t+1+SETTLE; ADC_DONE at cycle d gives ACK at d+1. Next grant earliest at d+2.
- ADC_DONE outside CONVERT is ignored. ADC_DONE coincident with the ADC_START cycle is ignored.
- MUX_SEL holds its last value while IDLE; only MUX_EN drops.

Optional Feature:
Macro TUB_ADC_TIMEOUT_EN.
- Defined:
  - CONVERT runs a 16-bit counter. If TMO cycles elapse without ADC_DONE, go to DONE with DATA = all ones and ERR = 1 together with ACK.
  - ADC_DONE arriving in the same cycle the count expires counts as a normal completion (ERR = 0).
- Undefined: CONVERT waits indefinitely; ERR is constant 0; no timeout counter is synthesized.

Test Plan:
- Reset release, REQ[2] pulse at cycle 0 -> MUX_SEL = 2 and MUX_EN = 1 at cycle 2, ADC_START at cycle 18; ADC_DONE with ADC_DATA = 0xA5C three cycles later -> ACK = 4'b0100, DATA = 0xA5C one cycle after; BUSY low the following cycle.
- REQ = 4'b1111 in one cycle, ADC answering after 5 cycles -> served in order 0, 1, 2, 3, one ACK each, four ADC_START pulses total.
- After channel 1 served, REQ[0] and REQ[2] together -> channel 2 served before channel 0 (pointer = 2).
- REQ[3] pulsed three times while pending, plus once during its SETTLE -> exactly two conversions for channel 3.
- Stray ADC_DONE in IDLE and during SETTLE -> no ACK, DATA unchanged. RESET_N low during CONVERT -> all outputs 0 immediately, no ACK after release.
- With TUB_ADC_TIMEOUT_EN and ADC_DONE withheld -> ACK with ERR = 1 and DATA = 0xFFF exactly 201 cycles after ADC_START. Without the macro -> BUSY stays high and no ACK.
